// File: rtl/tetris_pkg.sv
// Shared types and constants for the tetris keyboard input conditioning path.
package tetris_pkg;

  localparam int unsigned TICK_CNT_W = 6;
  localparam int unsigned DEF_DAS    = 10;
  localparam int unsigned DEF_ARR    = 3;

  // Bit positions of each key in the packed key vectors used by the top level.
  localparam int unsigned NUM_KEYS   = 5;
  localparam int unsigned KEY_LEFT   = 0;
  localparam int unsigned KEY_RIGHT  = 1;
  localparam int unsigned KEY_DOWN   = 2;
  localparam int unsigned KEY_ROTATE = 3;
  localparam int unsigned KEY_DROP   = 4;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_DELAY  = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_t;

  // True when an incremented tick count has reached its threshold.
  function automatic logic cnt_hit(input logic [TICK_CNT_W-1:0] cnt_next,
                                   input int unsigned          limit);
    return cnt_next == TICK_CNT_W'(limit);
  endfunction

endpackage

// File: rtl/key_repeat_fsm.sv
// Auto-repeat generator for one synchronised key: press, delayed auto shift,
// then fixed-rate repeat; drives a pending request flop cleared by each game tick.
module key_repeat_fsm
  import tetris_pkg::*;
#(
  parameter int unsigned DAS = DEF_DAS,
  parameter int unsigned ARR = DEF_ARR
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_level,
  input  logic key_press,
  input  logic cancel,
  input  logic kill,
  output logic pending
);

  rep_state_t                state, state_n;
  logic [TICK_CNT_W-1:0]     cnt, cnt_n;
  logic [TICK_CNT_W-1:0]     cnt_inc;
  logic                      pending_n;
  logic                      set_req;

  assign cnt_inc = cnt + TICK_CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= REP_IDLE;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pending <= pending_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    set_req = 1'b0;

    if (cancel || kill || !key_level) begin
      state_n = REP_IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        REP_IDLE: begin
          if (key_press) begin
            state_n = REP_DELAY;
            cnt_n   = '0;
            set_req = 1'b1;
          end
        end
        REP_DELAY: begin
          if (tick) begin
            cnt_n = cnt_inc;
            if (cnt_hit(cnt_inc, DAS)) begin
              state_n = REP_REPEAT;
              cnt_n   = '0;
              set_req = 1'b1;
            end
          end
        end
        REP_REPEAT: begin
          if (tick) begin
            cnt_n = cnt_inc;
            if (cnt_hit(cnt_inc, ARR)) begin
              cnt_n   = '0;
              set_req = 1'b1;
            end
          end
        end
        default: begin
          state_n = REP_IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    // A new event beats the tick-consume clear so it is seen at the next tick.
    if (cancel || kill) begin
      pending_n = 1'b0;
    end else if (set_req) begin
      pending_n = 1'b1;
    end else if (tick) begin
      pending_n = 1'b0;
    end else begin
      pending_n = pending;
    end
  end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Turns raw held-key levels into per-tick move requests for tetris_game:
// synchronisation, press detection, auto-repeat, left/right arbitration, game-over gating.
module tetris_input_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned DAS_TICKS      = DEF_DAS,
  parameter int unsigned ARR_TICKS      = DEF_ARR,
  parameter int unsigned DOWN_DAS_TICKS = 1,
  parameter int unsigned DOWN_ARR_TICKS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_game,
  input  logic game_over,
  input  logic raw_left,
  input  logic raw_right,
  input  logic raw_down,
  input  logic raw_rotate,
  input  logic raw_drop,
  output logic key_left,
  output logic key_right,
  output logic key_down,
  output logic key_rotate,
  output logic key_drop
);

  logic [NUM_KEYS-1:0] raw_vec;
  logic [NUM_KEYS-1:0] sync_q1, sync_q2, hist_q;
  logic [NUM_KEYS-1:0] press;

  logic press_left, press_right;
  logic cancel_left, cancel_right;
  logic rotate_pend, drop_pend;

  assign raw_vec = {raw_drop, raw_rotate, raw_down, raw_right, raw_left};

  // Two-flop synchroniser plus history flop; history runs even in game over
  // so a key held across game_over falling needs a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      hist_q  <= '0;
    end else begin
      sync_q1 <= raw_vec;
      sync_q2 <= sync_q1;
      hist_q  <= sync_q2;
    end
  end

  assign press = sync_q2 & ~hist_q & {NUM_KEYS{~game_over}};

  // Simultaneous left+right presses cancel each other; a lone press pre-empts a held opposite.
  assign press_left   = press[KEY_LEFT]  & ~press[KEY_RIGHT];
  assign press_right  = press[KEY_RIGHT] & ~press[KEY_LEFT];
  assign cancel_left  = press_right & sync_q2[KEY_LEFT];
  assign cancel_right = press_left  & sync_q2[KEY_RIGHT];

  key_repeat_fsm #(
    .DAS (DAS_TICKS),
    .ARR (ARR_TICKS)
  ) u_rep_left (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick_game),
    .key_level (sync_q2[KEY_LEFT]),
    .key_press (press_left),
    .cancel    (cancel_left),
    .kill      (game_over),
    .pending   (key_left)
  );

  key_repeat_fsm #(
    .DAS (DAS_TICKS),
    .ARR (ARR_TICKS)
  ) u_rep_right (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick_game),
    .key_level (sync_q2[KEY_RIGHT]),
    .key_press (press_right),
    .cancel    (cancel_right),
    .kill      (game_over),
    .pending   (key_right)
  );

  key_repeat_fsm #(
    .DAS (DOWN_DAS_TICKS),
    .ARR (DOWN_ARR_TICKS)
  ) u_rep_down (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick_game),
    .key_level (sync_q2[KEY_DOWN]),
    .key_press (press[KEY_DOWN]),
    .cancel    (1'b0),
    .kill      (game_over),
    .pending   (key_down)
  );

  // Rotate and drop are single-shot per press; set beats the tick-consume clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rotate_pend <= 1'b0;
      drop_pend   <= 1'b0;
    end else if (game_over) begin
      rotate_pend <= 1'b0;
      drop_pend   <= 1'b0;
    end else begin
      if (press[KEY_ROTATE]) begin
        rotate_pend <= 1'b1;
      end else if (tick_game) begin
        rotate_pend <= 1'b0;
      end
      if (press[KEY_DROP]) begin
        drop_pend <= 1'b1;
      end else if (tick_game) begin
        drop_pend <= 1'b0;
      end
    end
  end

  assign key_rotate = rotate_pend;
  assign key_drop   = drop_pend;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed self-checking bench for tetris_input_ctrl with default parameters.
module tb_tetris_input_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic tick_game;
  logic game_over;
  logic raw_left, raw_right, raw_down, raw_rotate, raw_drop;
  logic key_left, key_right, key_down, key_rotate, key_drop;
  logic [4:0] keys;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tetris_input_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick_game  (tick_game),
    .game_over  (game_over),
    .raw_left   (raw_left),
    .raw_right  (raw_right),
    .raw_down   (raw_down),
    .raw_rotate (raw_rotate),
    .raw_drop   (raw_drop),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_down   (key_down),
    .key_rotate (key_rotate),
    .key_drop   (key_drop)
  );

  // Vector order: {drop, rotate, down, right, left}
  assign keys = {key_drop, key_rotate, key_down, key_right, key_left};

  task automatic check(input string tag, input logic [4:0] exp);
    n_assert++;
    assert (keys === exp) else begin
      n_fail++;
      $error("FAIL %s: keys=%b expected=%b", tag, keys, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One tick_game cycle; the outputs seen during it are what the game consumes.
  task automatic tick_chk(input string tag, input logic [4:0] exp);
    tick_game = 1'b1;
    check(tag, exp);
    @(posedge clk);
    #1;
    tick_game = 1'b0;
    cycles(2);
  endtask

  initial begin
    rst        = 1'b1;
    tick_game  = 1'b0;
    game_over  = 1'b0;
    raw_left   = 1'b0;
    raw_right  = 1'b0;
    raw_down   = 1'b0;
    raw_rotate = 1'b0;
    raw_drop   = 1'b0;
    cycles(3);
    check("reset", 5'b00000);
    rst = 1'b0;
    cycles(2);

    // Rotate: 5-cycle pulse, request only at tick 1
    raw_rotate = 1'b1;
    cycles(5);
    raw_rotate = 1'b0;
    cycles(2);
    tick_chk("rot_t1", 5'b01000);
    tick_chk("rot_t2", 5'b00000);
    tick_chk("rot_t3", 5'b00000);

    // Left held: requests at ticks 1, 11, 14, 17, 20 (and 23)
    raw_left = 1'b1;
    cycles(4);
    for (int t = 1; t <= 22; t++) begin
      logic hit;
      hit = (t == 1) || (t == 11) || (t == 14) || (t == 17) || (t == 20);
      tick_chk($sformatf("left_t%0d", t), {4'b0000, hit});
    end
    check("left_pend_t23", 5'b00001);
    rst = 1'b1;
    #2;
    check("rst_async", 5'b00000);
    raw_left = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(2);
    tick_chk("post_rst", 5'b00000);

    // Down held 5 ticks, released before tick 6
    raw_down = 1'b1;
    cycles(4);
    for (int t = 1; t <= 5; t++) tick_chk($sformatf("down_t%0d", t), 5'b00100);
    raw_down = 1'b0;
    cycles(4);
    tick_chk("down_t6_pending", 5'b00100);
    tick_chk("down_t7", 5'b00000);
    tick_chk("down_t8", 5'b00000);

    // Left into REPEAT, then right pre-empts it
    raw_left = 1'b1;
    cycles(4);
    for (int t = 1; t <= 13; t++) begin
      logic hit;
      hit = (t == 1) || (t == 11);
      tick_chk($sformatf("conf_left_t%0d", t), {4'b0000, hit});
    end
    check("conf_left_pend", 5'b00001);
    raw_right = 1'b1;
    cycles(4);
    check("conf_left_cleared", 5'b00010);
    tick_chk("conf_right_t1", 5'b00010);
    for (int t = 2; t <= 4; t++) tick_chk($sformatf("conf_right_t%0d", t), 5'b00000);
    raw_right = 1'b0;
    cycles(4);
    for (int t = 1; t <= 15; t++) tick_chk($sformatf("conf_noresume_t%0d", t), 5'b00000);
    raw_left = 1'b0;
    cycles(4);

    // Simultaneous left+right presses are both ignored
    raw_left  = 1'b1;
    raw_right = 1'b1;
    cycles(4);
    check("both_pre", 5'b00000);
    for (int t = 1; t <= 15; t++) tick_chk($sformatf("both_t%0d", t), 5'b00000);
    raw_left  = 1'b0;
    raw_right = 1'b0;
    cycles(4);

    // Game over silences everything; held drop needs a fresh press afterwards
    game_over = 1'b1;
    cycles(2);
    raw_left   = 1'b1;
    raw_right  = 1'b1;
    raw_down   = 1'b1;
    raw_rotate = 1'b1;
    raw_drop   = 1'b1;
    cycles(4);
    check("go_pre", 5'b00000);
    for (int t = 1; t <= 3; t++) tick_chk($sformatf("go_t%0d", t), 5'b00000);
    raw_left   = 1'b0;
    raw_right  = 1'b0;
    raw_down   = 1'b0;
    raw_rotate = 1'b0;
    cycles(4);
    game_over = 1'b0;
    cycles(4);
    tick_chk("go_drop_held", 5'b00000);
    raw_drop = 1'b0;
    cycles(4);
    raw_drop = 1'b1;
    cycles(4);
    tick_chk("go_drop_repress", 5'b10000);
    tick_chk("go_drop_after", 5'b00000);
    raw_drop = 1'b0;
    cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tetris_input_ctrl.md
# tetris_input_ctrl

Conditions raw held-key levels from the keyboard decoder into per-game-tick move requests for `tetris_game`. Its outputs connect directly to that block's `key_left/right/down/rotate/drop` inputs. Each output is a level that stays stable until the next `tick_game` cycle, where the game consumes it. The block synchronises the raw keys, detects presses, and generates auto-repeat: delayed auto shift (DAS) then a fixed auto-repeat rate (ARR) for left/right, and continuous repeat for down. It also resolves left/right conflicts and silences all input while `game_over` is high.

## Interface
Parameters:
- `DAS_TICKS`, 10: ticks from the first move to the first repeat, left/right. Range 1..63.
- `ARR_TICKS`, 3: ticks between repeats, left/right. Range 1..63.
- `DOWN_DAS_TICKS`, 1: delay for down. Range 1..63.
- `DOWN_ARR_TICKS`, 1: repeat period for down. Range 1..63.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `tick_game` in 1: one-cycle game-rate strobe, shared with `tetris_game`.
- `game_over` in 1: from `tetris_game`; suppresses all requests.
- `raw_left`, `raw_right`, `raw_down`, `raw_rotate`, `raw_drop` in 1 each: asynchronous held-key levels.
- `key_left`, `key_right`, `key_down`, `key_rotate`, `key_drop` out 1 each: registered request levels.

## Operation
- Synchronisation:
  - Each raw key passes through a 2-flop synchroniser, then a history flop.
  - A press edge is sync high while history is low. A release is the sync level going low.
- Pending flags: one per key; each output is driven directly by its pending flop.
  - Set by a press edge or a repeat event.
  - Cleared on the clock edge that ends a `tick_game` cycle (the game has sampled it).
  - If set and clear occur in the same cycle, set wins: the event is seen at the next tick.
- Rotate and drop are press-edge only; there is no repeat.
- Left, right and down each have a repeat FSM with states IDLE, DELAY and REPEAT, plus a 6-bit tick counter `cnt`:
  - IDLE -> DELAY on a press edge: set pending, `cnt` = 0.
  - In DELAY, on each tick: `cnt` = `cnt`+1. When the new `cnt` equals DAS, go to REPEAT, set `cnt` = 0 and set pending.
  - In REPEAT, on each tick: `cnt` = `cnt`+1. When the new `cnt` equals ARR, set `cnt` = 0 and set pending.
  - Any state -> IDLE on release. `cnt` is cleared; a pending flag that is already set is kept.
- Left/right conflict:
  - A press edge on one direction while the other is held forces the other FSM to IDLE and clears its pending flag.
  - The cancelled direction does not resume on the winner's release; it needs a fresh press.
  - Press edges on both in the same cycle are both ignored: both FSMs go to IDLE and neither pending flag is set.
- Game over: while `game_over` is high, all FSMs are held in IDLE, all pending flags are cleared, and all outputs are 0.
  - Press edges during game over are discarded.
  - A key still held when `game_over` falls does not generate an event until it is re-pressed.
- Rotate and drop may be asserted in the same tick, alongside any movement output.

## Timing
- Reset: all synchroniser, history and pending flops are 0, all FSMs are IDLE, `cnt` is 0, and all outputs are 0. This holds asynchronously, including reset mid-repeat.
- Press latency:
  - Raw high sampled at edge 0; the synchroniser is high at edge 1.
  - The press edge is detected on the following cycle, so the output rises after edge 2.
- Repeat schedule: tick 1 is the first tick at which the press is sampled.
  - With DAS=10 and ARR=3, held left yields requests at ticks 1, 11, 14, 17, …
  - With DOWN_DAS=1 and DOWN_ARR=1, held down yields a request every tick.
- Counters advance only in `tick_game` cycles and do not wrap: they reset to 0 on reaching ARR, and DAS/ARR are at most 63.
- Outputs change only on clock edges, never combinationally from `tick_game`.

## Structure
- Package `tetris_pkg` holds:
  - the typedef `rep_state_t` {REP_IDLE, REP_DELAY, REP_REPEAT};
  - the constants `TICK_CNT_W` = 6, `DEF_DAS` = 10, `DEF_ARR` = 3.
- Sub-module `key_repeat_fsm`: one synchronised key in, with parameters DAS/ARR and inputs for tick, cancel and kill. It contains the FSM, counter and pending flop. It is instantiated three times.
- Rotate and drop are handled by inline edge detection plus pending flops.
- Conflict arbitration and game-over gating live in the top level.

## Test plan
- Reset, then pulse `raw_rotate` high for 5 cycles, then 3 ticks:
  - `key_rotate` = 1 exactly at tick 1, and 0 after that edge.
  - Re-assert `rst` while `raw_left` is held in REPEAT: all outputs go to 0 immediately.
- Hold `raw_left` for 20 ticks with default parameters:
  - `key_left` is high at ticks 1, 11, 14, 17, 20 and low at all other ticks.
  - `key_right` stays 0 throughout.
- Hold `raw_down` for 5 ticks: `key_down` is high at ticks 1–5.
  - Release before tick 6: no request at tick 6, except the one already pending.
- Hold left into REPEAT, then press right:
  - `key_left` pending is cleared and `key_right` is seen at the next tick.
  - Release right with left still held: no further left requests.
- Assert raw left and raw right rising in the same cycle: no movement request over the next 15 ticks.
- Hold `game_over` = 1 and press every key: all outputs stay 0.
  - Drop `game_over` with drop still held: `key_drop` stays 0.
  - Re-press drop: `key_drop` = 1 at the next tick.
